// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pkg
//  Description : Shared types and default timing constants for the LED
//                serial-stream decoder. All timing values are in cycles
//                of a 100 MHz clock.
//                Contents:
//                  led_state_e   - decoder FSM states
//                  grb_pixel_t   - 24-bit GRB pixel word
//                  DEF_*         - default parameter values
//                  max2()        - elaboration-time maximum helper
//  Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_IDLE = 2'd1,
    S_HIGH = 2'd2,
    S_LOW  = 2'd3
  } led_state_e;

  typedef logic [23:0] grb_pixel_t;

  localparam int unsigned PIXEL_BITS       = 24;
  localparam int unsigned DEF_NUM_LEDS     = 10;
  localparam int unsigned DEF_BIT_THRESH   = 60;    // 600 ns
  localparam int unsigned DEF_MIN_HIGH     = 20;    // 200 ns
  localparam int unsigned DEF_MAX_HIGH     = 100;   // 1 us
  localparam int unsigned DEF_LATCH_CYCLES = 5000;  // 50 us

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_line_sync.sv
`default_nettype none
// ============================================================================
//  Module      : led_line_sync
//  Description : Two-flop synchronizer for the asynchronous LED data line,
//                followed by a history flop for edge detection.
//  Ports       : clk_i   - clock
//                rst_ni  - asynchronous active-low reset
//                line_i  - raw asynchronous serial line
//                level_o - synchronized line level
//                rise_o  - one-cycle pulse on a synchronized rising edge
//                fall_o  - one-cycle pulse on a synchronized falling edge
//  Revision    : 1.0 - initial release
// ============================================================================
module led_line_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/led_stream_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : led_stream_decoder
//  Description : Decodes a single-wire LED pixel stream (pulse-width coded
//                bits, 24-bit GRB pixels, frames terminated by a long low
//                latch gap) into pixel words with their frame position.
//  Ports       : clk_100mhz  - 100 MHz clock
//                sys_rst_n   - asynchronous active-low reset
//                signal_in   - asynchronous serial LED data line
//                pixel_data  - decoded GRB word, MSB received first
//                pixel_valid - one-cycle strobe for pixel_data/pixel_index
//                pixel_index - zero-based pixel position within the frame
//                frame_done  - one-cycle strobe on a valid latch gap
//                frame_error - one-cycle strobe on a protocol violation
//  Options     : PIXEL_COUNT_CHECK_EN - when defined, a frame must contain
//                exactly NUM_LEDS pixels; otherwise pixel_index wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_stream_decoder
  import led_pkg::*;
#(
  parameter int unsigned NUM_LEDS     = DEF_NUM_LEDS,
  parameter int unsigned BIT_THRESH   = DEF_BIT_THRESH,
  parameter int unsigned MIN_HIGH     = DEF_MIN_HIGH,
  parameter int unsigned MAX_HIGH     = DEF_MAX_HIGH,
  parameter int unsigned LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input  logic                        clk_100mhz,
  input  logic                        sys_rst_n,
  input  logic                        signal_in,
  output logic [23:0]                 pixel_data,
  output logic                        pixel_valid,
  output logic [$clog2(NUM_LEDS):0]   pixel_index,
  output logic                        frame_done,
  output logic                        frame_error
);

  // Counters must reach both the latch length and the high-time timeout.
  localparam int unsigned CNT_MAX = max2(LATCH_CYCLES, MAX_HIGH + 1);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = $clog2(NUM_LEDS) + 1;

  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_THRESH   = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] C_MIN      = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] C_MAX      = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] C_LATCH    = CNT_W'(LATCH_CYCLES);
  localparam logic [4:0]       C_LAST_BIT = 5'(PIXEL_BITS - 1);
`ifdef PIXEL_COUNT_CHECK_EN
  localparam logic [IDX_W-1:0] C_NUM      = IDX_W'(NUM_LEDS);
`else
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_LEDS - 1);
`endif

  // Line synchronizer and edge detection
  logic w_level;
  logic w_rise;
  logic w_fall;

  led_line_sync u_line_sync (
    .clk_i   (clk_100mhz),
    .rst_ni  (sys_rst_n),
    .line_i  (signal_in),
    .level_o (w_level),
    .rise_o  (w_rise),
    .fall_o  (w_fall)
  );

  // State
  led_state_e        state_q, state_d;
  logic [CNT_W-1:0]  width_q, width_d;
  logic [CNT_W-1:0]  low_q, low_d;
  logic [4:0]        bitcnt_q, bitcnt_d;
  logic [22:0]       shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  grb_pixel_t        pixel_data_q, pixel_data_d;
  logic [IDX_W-1:0]  pixel_index_q, pixel_index_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              w_bit;
  logic              w_abort;

  assign w_bit = (width_q >= C_THRESH);

  always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= S_SYNC;
      width_q       <= '0;
      low_q         <= '0;
      bitcnt_q      <= '0;
      shift_q       <= '0;
      idx_q         <= '0;
      pixel_data_q  <= '0;
      pixel_index_q <= '0;
      valid_q       <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      width_q       <= width_d;
      low_q         <= low_d;
      bitcnt_q      <= bitcnt_d;
      shift_q       <= shift_d;
      idx_q         <= idx_d;
      pixel_data_q  <= pixel_data_d;
      pixel_index_q <= pixel_index_d;
      valid_q       <= valid_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    width_d       = width_q;
    low_d         = low_q;
    bitcnt_d      = bitcnt_q;
    shift_d       = shift_q;
    idx_d         = idx_q;
    pixel_data_d  = pixel_data_q;
    pixel_index_d = pixel_index_q;
    valid_d       = 1'b0;
    done_d        = 1'b0;
    err_d         = 1'b0;
    w_abort       = 1'b0;

    case (state_q)
      // Wait for an unbroken low of a full latch length before trusting
      // the stream; this gap only aligns us, it does not end a frame.
      S_SYNC: begin
        if (w_level) begin
          low_d = '0;
        end else if (low_q == C_LATCH) begin
          state_d = S_IDLE;
        end else begin
          low_d = low_q + 1'b1;
        end
      end

      // The rise cycle is itself the first high cycle, so the counter
      // restarts at one and holds the exact high width at the fall.
      S_IDLE: begin
        if (w_rise) begin
          state_d = S_HIGH;
          width_d = C_ONE;
        end
      end

      S_HIGH: begin
        if (w_fall) begin
          if (width_q < C_MIN) begin
            w_abort = 1'b1;
          end else begin
            shift_d = {shift_q[21:0], w_bit};
            state_d = S_LOW;
            low_d   = C_ONE;  // fall cycle is the first low cycle
            if (bitcnt_q == C_LAST_BIT) begin
              bitcnt_d = '0;
`ifdef PIXEL_COUNT_CHECK_EN
              if (idx_q == C_NUM) begin
                w_abort = 1'b1;
              end else begin
                valid_d       = 1'b1;
                pixel_data_d  = {shift_q, w_bit};
                pixel_index_d = idx_q;
                idx_d         = idx_q + 1'b1;
              end
`else
              valid_d       = 1'b1;
              pixel_data_d  = {shift_q, w_bit};
              pixel_index_d = idx_q;
              idx_d         = (idx_q == C_LAST_IDX) ? '0 : idx_q + 1'b1;
`endif
            end else begin
              bitcnt_d = bitcnt_q + 1'b1;
            end
          end
        end else if (width_q >= C_MAX) begin
          // Line is still high on what would be cycle MAX_HIGH+1.
          w_abort = 1'b1;
        end else begin
          width_d = width_q + 1'b1;
        end
      end

      S_LOW: begin
        if (w_rise) begin
          state_d = S_HIGH;
          width_d = C_ONE;
        end else if (low_q == C_LATCH) begin
          state_d  = S_IDLE;
          bitcnt_d = '0;
          idx_d    = '0;
          // S_LOW is only entered through an accepted bit, so a zero bit
          // count here means at least one whole pixel has been received.
          if (bitcnt_q != '0) begin
            err_d = 1'b1;
          end
`ifdef PIXEL_COUNT_CHECK_EN
          else if (idx_q == C_NUM) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
`else
          else begin
            done_d = 1'b1;
          end
`endif
        end else begin
          low_d = low_q + 1'b1;
        end
      end

      default: begin
        state_d = S_SYNC;
      end
    endcase

    // Any protocol violation drops all partial state and forces a resync.
    if (w_abort) begin
      state_d  = S_SYNC;
      err_d    = 1'b1;
      valid_d  = 1'b0;
      bitcnt_d = '0;
      idx_d    = '0;
      low_d    = '0;
    end
  end

  assign pixel_data  = pixel_data_q;
  assign pixel_valid = valid_q;
  assign pixel_index = pixel_index_q;
  assign frame_done  = done_q;
  assign frame_error = err_q;

endmodule
`default_nettype wire

// File: tb/tb_led_stream_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_stream_decoder
//  Description : Self-checking bench for led_stream_decoder. Pulses are
//                driven on the serial line; a line-level reference model
//                predicts the pixel / frame_done / frame_error event
//                sequence, which is compared with the events captured from
//                the DUT. The latch length is shortened to keep runs short.
//  Options     : PIXEL_COUNT_CHECK_EN changes the model in step with the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_stream_decoder;

  localparam int NUM_LEDS   = 10;
  localparam int BIT_THRESH = 60;
  localparam int MIN_HIGH   = 20;
  localparam int MAX_HIGH   = 100;
  localparam int LATCH      = 600;
  localparam int GAP        = LATCH + 60;

  localparam int EV_PIX  = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sig = 1'b0;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [4:0]  pixel_index;
  logic        frame_done;
  logic        frame_error;

  always #5 clk = ~clk;

  led_stream_decoder #(
    .NUM_LEDS     (NUM_LEDS),
    .BIT_THRESH   (BIT_THRESH),
    .MIN_HIGH     (MIN_HIGH),
    .MAX_HIGH     (MAX_HIGH),
    .LATCH_CYCLES (LATCH)
  ) dut (
    .clk_100mhz  (clk),
    .sys_rst_n   (rst_n),
    .signal_in   (sig),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_index (pixel_index),
    .frame_done  (frame_done),
    .frame_error (frame_error)
  );

  typedef struct {
    int          kind;
    logic [23:0] data;
    int          idx;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (line-level protocol rules) ----------
  bit          m_synced;
  int          m_nbits;
  logic [23:0] m_word;
  int          m_count;
  logic [23:0] m_last;

  task automatic push_exp(input int kind, input logic [23:0] data, input int idx);
    ev_t e;
    e.kind = kind; e.data = data; e.idx = idx;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_synced = 0; m_nbits = 0; m_word = '0; m_count = 0; m_last = '0;
  endtask

  task automatic model_pulse(input int h);
    if (!m_synced) return;
    if (h < MIN_HIGH || h > MAX_HIGH) begin
      push_exp(EV_ERR, '0, 0);
      m_synced = 0; m_nbits = 0; m_count = 0;
      return;
    end
    m_word  = m_word * 2 + ((h >= BIT_THRESH) ? 1 : 0);
    m_nbits = m_nbits + 1;
    if (m_nbits == 24) begin
      m_nbits = 0;
`ifdef PIXEL_COUNT_CHECK_EN
      if (m_count == NUM_LEDS) begin
        push_exp(EV_ERR, '0, 0);
        m_synced = 0; m_count = 0;
        return;
      end
`endif
      push_exp(EV_PIX, m_word, m_count % NUM_LEDS);
      m_last  = m_word;
      m_count = m_count + 1;
    end
  endtask

  task automatic model_gap();
    if (!m_synced) begin
      m_synced = 1;
      return;
    end
    if (m_nbits != 0) begin
      push_exp(EV_ERR, '0, 0);
    end else if (m_count > 0) begin
`ifdef PIXEL_COUNT_CHECK_EN
      push_exp((m_count == NUM_LEDS) ? EV_DONE : EV_ERR, '0, 0);
`else
      push_exp(EV_DONE, '0, 0);
`endif
    end
    m_nbits = 0;
    m_count = 0;
  endtask

  // ---------------- event capture ----------------------------------------
  always @(negedge clk) begin
    ev_t e;
    if (pixel_valid === 1'b1) begin
      e.kind = EV_PIX; e.data = pixel_data; e.idx = int'(pixel_index);
      obs_q.push_back(e);
    end
    if (frame_done === 1'b1) begin
      e.kind = EV_DONE; e.data = '0; e.idx = 0;
      obs_q.push_back(e);
    end
    if (frame_error === 1'b1) begin
      e.kind = EV_ERR; e.data = '0; e.idx = 0;
      obs_q.push_back(e);
    end
    if (frame_done === 1'b1 || frame_error === 1'b1)
      chk("done_err_exclusive", {31'b0, frame_done & frame_error}, 32'd0);
  end

  // ---------------- line drivers -----------------------------------------
  task automatic pulse(input int h, input int l);
    sig = 1'b1;
    repeat (h) @(negedge clk);
    sig = 1'b0;
    repeat (l) @(negedge clk);
    model_pulse(h);
  endtask

  task automatic send_bit(input bit b);
    int h;
    h = b ? int'($urandom_range(MAX_HIGH, BIT_THRESH))
          : int'($urandom_range(BIT_THRESH - 1, MIN_HIGH));
    pulse(h, int'($urandom_range(20, 8)));
  endtask

  task automatic send_pixel(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_pixel_fast(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) pulse(w[i] ? 65 : 25, 10);
  endtask

  task automatic gap();
    sig = 1'b0;
    repeat (GAP) @(negedge clk);
    model_gap();
  endtask

  task automatic compare(input string tag);
    int n;
    repeat (8) @(negedge clk);
    chk({tag, "_events"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_kind"}, obs_q[i].kind, exp_q[i].kind);
      if (exp_q[i].kind == EV_PIX) begin
        chk({tag, "_data"}, {8'b0, obs_q[i].data}, {8'b0, exp_q[i].data});
        chk({tag, "_index"}, obs_q[i].idx, exp_q[i].idx);
      end
    end
    chk({tag, "_hold"}, {8'b0, pixel_data}, {8'b0, m_last});
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_data"}, {8'b0, pixel_data}, 32'd0);
    chk({tag, "_index"}, {27'b0, pixel_index}, 32'd0);
    chk({tag, "_valid"}, {31'b0, pixel_valid}, 32'd0);
    chk({tag, "_done"}, {31'b0, frame_done}, 32'd0);
    chk({tag, "_error"}, {31'b0, frame_error}, 32'd0);
  endtask

  // ---------------- directed sequence ------------------------------------
  initial begin
    logic [23:0] w;
    int          npix;

    model_reset();
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    // Initial alignment gap must not produce frame_done.
    gap();
    compare("sync");

    // 0xFF0000 at 80/45, with the strobe latency checked on the last bit.
    w = 24'hFF0000;
    for (int i = 23; i >= 1; i--) pulse(w[i] ? 80 : 30, 45);
    sig = 1'b1;
    repeat (30) @(negedge clk);
    sig = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("latency_early", {31'b0, pixel_valid}, 32'd0);
    @(posedge clk); #1;
    chk("latency_3", {31'b0, pixel_valid}, 32'd1);
    @(negedge clk);
    repeat (42) @(negedge clk);
    model_pulse(30);
    gap();
    compare("first_pixel");

    // Full frame of alternating pixels.
    for (int p = 0; p < NUM_LEDS; p++) send_pixel_fast((p % 2) ? 24'h0000FF : 24'h00FF00);
    gap();
    compare("frame10");

    // Partial pixel at the latch gap, then a clean pixel.
    for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(1, 0)));
    gap();
    send_pixel(24'($urandom));
    gap();
    compare("partial");

    // Too-short high pulse; following bits ignored until resync.
    pulse(10, 30);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    gap();
    send_pixel(24'($urandom));
    gap();
    compare("short_pulse");

    // Too-long high pulse.
    pulse(150, 30);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    gap();
    send_pixel(24'($urandom));
    gap();
    compare("long_pulse");

    // Width limits just outside the legal range.
    pulse(MIN_HIGH - 1, 30);
    gap();
    pulse(MAX_HIGH + 1, 30);
    gap();
    compare("limits_out");

    // Widths exactly on the legal and threshold edges: 0,0,1,1 repeating.
    for (int i = 0; i < 24; i++) begin
      case (i % 4)
        0:       pulse(MIN_HIGH, 12);
        1:       pulse(BIT_THRESH - 1, 12);
        2:       pulse(BIT_THRESH, 12);
        default: pulse(MAX_HIGH, 12);
      endcase
    end
    gap();
    compare("limits_in");

    // Reset in the middle of a pixel.
    for (int i = 0; i < 13; i++) send_bit(1'b1);
    compare("pre_reset");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("mid_reset");
    model_reset();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    gap();
    send_pixel(24'($urandom));
    gap();
    compare("after_reset");

    // Random short frame.
    npix = int'($urandom_range(4, 1));
    for (int p = 0; p < npix; p++) send_pixel(24'($urandom));
    gap();
    compare("random_frame");

    // One pixel more than a frame: index wrap, or overflow error when checked.
    for (int p = 0; p < NUM_LEDS + 1; p++) send_pixel_fast(24'($urandom));
    gap();
    gap();
    send_pixel_fast(24'hA5C33C);
    gap();
    compare("overflow");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
